// File: rtl/sdram_host_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sdram_host_queue                                           |
// | Description : Host request FIFO in front of sdram_controller. Issues one |
// |               request at a time on the controller interface, gated by    |
// |               ctrl_busy. Read data goes back through a valid/ready       |
// |               response register, in request order.                       |
// |               Optional read timeout: define SDRAM_HQ_TIMEOUT_EN.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sdram_host_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic              ctrl_wr_enable,
    output logic              ctrl_rd_enable,
    input  logic              ctrl_busy,
    input  logic [DATA_W-1:0] ctrl_rd_data,
    input  logic              ctrl_rd_ready
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 1 + ADDR_W + DATA_W;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_RD_WAIT = 2'd2;
    localparam logic [1:0] c_ST_BUSY_W  = 2'd3;

    // FIFO storage and bookkeeping; each entry is {write, addr, wdata}
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Controller-side sequencing and response register
    logic [1:0]         r_state;
    logic               r_op_write;
    logic               r_wr_en;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_head_write;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_wdata;

`ifdef SDRAM_HQ_TIMEOUT_EN
    localparam int c_TO_W = $clog2(RD_TIMEOUT + 1);
    logic [c_TO_W-1:0]  r_timer;
    logic               r_rsp_err;
`endif

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign req_ready = ~w_full;
    assign w_push    = req_valid & ~w_full;

    assign {w_head_write, w_head_addr, w_head_wdata} = r_mem[r_rd_ptr];

    // A read may only leave the queue when its response has somewhere to land;
    // writes never produce a response and are not held back by it.
    assign w_pop = (r_state == c_ST_IDLE) & ~w_empty & ~ctrl_busy &
                   (w_head_write | ~r_rsp_valid);

    assign ctrl_addr      = r_addr;
    assign ctrl_wdata     = r_wdata;
    assign ctrl_wr_enable = r_wr_en;
    assign ctrl_rd_enable = r_rd_en;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;

`ifdef SDRAM_HQ_TIMEOUT_EN
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    // FIFO payload write; storage needs no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_write, req_addr, req_wdata};
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves the count alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM with registered controller outputs and response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_op_write  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef SDRAM_HQ_TIMEOUT_EN
            r_timer     <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            // Host handshake retires the response; a new one can only be
            // loaded in RD_WAIT, which is unreachable while one is pending.
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
`ifdef SDRAM_HQ_TIMEOUT_EN
                r_rsp_err   <= 1'b0;
`endif
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_addr     <= w_head_addr;
                        r_wdata    <= w_head_wdata;
                        r_op_write <= w_head_write;
                        r_wr_en    <= w_head_write;
                        r_rd_en    <= ~w_head_write;
                        r_state    <= c_ST_ISSUE;
                    end
                end

                c_ST_ISSUE: begin
                    // Controller has taken the command once it reports busy
                    if (ctrl_busy) begin
                        r_wr_en <= 1'b0;
                        r_rd_en <= 1'b0;
                        r_state <= r_op_write ? c_ST_BUSY_W : c_ST_RD_WAIT;
`ifdef SDRAM_HQ_TIMEOUT_EN
                        r_timer <= '0;
`endif
                    end
                end

                c_ST_RD_WAIT: begin
                    if (ctrl_rd_ready) begin
                        r_rsp_rdata <= ctrl_rd_data;
                        r_rsp_valid <= 1'b1;
`ifdef SDRAM_HQ_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= ctrl_busy ? c_ST_BUSY_W : c_ST_IDLE;
                    end
`ifdef SDRAM_HQ_TIMEOUT_EN
                    else if (r_timer == c_TO_W'(RD_TIMEOUT - 1)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= c_ST_BUSY_W;
                    end else begin
                        r_timer <= r_timer + c_TO_W'(1);
                    end
`endif
                end

                c_ST_BUSY_W: begin
                    if (!ctrl_busy) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
